// File: rtl/pll_recfg_seq.sv
// -----------------------------------------------------------------------------
// pll_recfg_seq
// Sequencer that reprograms the SDRAM-clock PLL through the Avalon-MM management
// port of pll_cfg. On a start request it latches the M/K/C0 words, issues the
// fixed eight-write reconfiguration sequence (with idle gaps between writes),
// pulses the PLL reset, waits for lock with a timeout, and reports done/error.
//
// Ports
//   clk                 in   1   management clock
//   rst_n               in   1   asynchronous active-low reset
//   start_i             in   1   1-cycle request; latches m/k/c0 words
//   abort_i             in   1   synchronous abort back to idle (highest priority)
//   m_val_i             in  32   M-counter word   (mgmt address 4)
//   k_val_i             in  32   fractional K word (mgmt address 7)
//   c0_val_i            in  32   C0-counter word  (mgmt address 5)
//   pll_locked_i        in   1   PLL lock, already synchronised to clk
//   mgmt_waitrequest_i  in   1   Avalon waitrequest from pll_cfg
//   mgmt_write_o        out  1   Avalon write strobe
//   mgmt_address_o      out  6   Avalon word address
//   mgmt_writedata_o    out 32   Avalon write data
//   pll_reset_o         out  1   PLL reset, active high
//   busy_o              out  1   sequence in progress
//   done_o              out  1   1-cycle completion pulse (success or timeout)
//   error_o             out  1   sticky lock-timeout flag, cleared by next start
// -----------------------------------------------------------------------------
module pll_recfg_seq #(
    parameter int unsigned GAP_CYCLES   = 8,
    parameter int unsigned RST_CYCLES   = 8,
    parameter int unsigned LOCK_TIMEOUT = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] m_val_i,
    input  logic [31:0] k_val_i,
    input  logic [31:0] c0_val_i,
    input  logic        pll_locked_i,
    input  logic        mgmt_waitrequest_i,
    output logic        mgmt_write_o,
    output logic [5:0]  mgmt_address_o,
    output logic [31:0] mgmt_writedata_o,
    output logic        pll_reset_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int unsigned CNT_MAX = (GAP_CYCLES > RST_CYCLES) ? GAP_CYCLES : RST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned TMR_W   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_PRST  = 3'd3,
        S_WLOCK = 3'd4,
        S_FIN   = 3'd5
    } state_e;

    // Reconfiguration write table: returns {address[5:0], data[31:0]} for a step.
    // Step 0 rewrites the mode register so pll_cfg is re-primed after any reset.
    function automatic logic [37:0] table_entry(input logic [2:0]  step,
                                                input logic [31:0] m,
                                                input logic [31:0] k,
                                                input logic [31:0] c0);
        logic [37:0] e;
        case (step)
            3'd0:    e = {6'd0, 32'h0000_0000};   // mode
            3'd1:    e = {6'd4, m};               // M counter
            3'd2:    e = {6'd7, k};               // fractional K
            3'd3:    e = {6'd3, 32'h0001_0000};   // N counter bypass
            3'd4:    e = {6'd5, c0};              // C0 counter
            3'd5:    e = {6'd9, 32'h0000_0001};   // charge pump
            3'd6:    e = {6'd8, 32'h0000_0007};   // bandwidth
            3'd7:    e = {6'd2, 32'h0000_0000};   // apply
            default: e = {6'd0, 32'h0000_0000};
        endcase
        return e;
    endfunction

    state_e             state_q, state_d;
    logic [2:0]         step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [31:0]        m_q, m_d, k_q, k_d, c0_q, c0_d;
    logic               error_q, error_d;
    logic               write_q, write_d;
    logic [5:0]         addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               prst_q, prst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [37:0]        entry_s;

    // Next-state logic; outputs are decoded from the next state so they leave flops.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        m_d     = m_q;
        k_d     = k_q;
        c0_d    = c0_q;
        error_d = error_q;

        if (abort_i) begin
            // Abort beats everything, including a simultaneous start; error is kept.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        m_d     = m_val_i;
                        k_d     = k_val_i;
                        c0_d    = c0_val_i;
                        step_d  = 3'd0;
                        error_d = 1'b0;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WRITE: begin
                    // write_q is always high here; acceptance is simply !waitrequest.
                    if (write_q && !mgmt_waitrequest_i) begin
                        cnt_d   = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
                S_GAP: begin
                    if (cnt_q <= CNT_ONE) begin
                        if (step_q == 3'd7) begin
                            cnt_d   = RST_LOAD;
                            state_d = S_PRST;
                        end else begin
                            step_d  = step_q + 3'd1;
                            state_d = S_WRITE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_PRST: begin
                    if (cnt_q <= CNT_ONE) begin
                        timer_d = '0;
                        state_d = S_WLOCK;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_WLOCK: begin
                    // Lock is tested first so it wins over a same-cycle timeout.
                    if (pll_locked_i) begin
                        error_d = 1'b0;
                        state_d = S_FIN;
                    end else if (timer_q >= TMR_LAST) begin
                        error_d = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        timer_d = timer_q + TMR_ONE;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        entry_s = table_entry(step_d, m_d, k_d, c0_d);
        write_d = (state_d == S_WRITE);
        if (write_d) begin
            addr_d = entry_s[37:32];
            data_d = entry_s[31:0];
        end else begin
            addr_d = 6'd0;
            data_d = 32'd0;
        end
        prst_d = (state_d == S_PRST);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // State, operand, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            cnt_q   <= '0;
            timer_q <= '0;
            m_q     <= 32'd0;
            k_q     <= 32'd0;
            c0_q    <= 32'd0;
            error_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 6'd0;
            data_q  <= 32'd0;
            prst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            m_q     <= m_d;
            k_q     <= k_d;
            c0_q    <= c0_d;
            error_q <= error_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            prst_q  <= prst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mgmt_write_o     = write_q;
    assign mgmt_address_o   = addr_q;
    assign mgmt_writedata_o = data_q;
    assign pll_reset_o      = prst_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign error_o          = error_q;

endmodule
